// File: rtl/toeplitz_pkg.sv
// Shared types and default geometry for the Toeplitz hash sequencer.
// Geometry legality is a pure function so every instance can check its own parameters.
package toeplitz_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_ROW_W  = 3072;
    localparam int DEF_N_ROWS = 1024;
    localparam int DEF_OUT_W  = 32;

    // A block must end exactly on a word boundary; the word index needs at least one bit.
    function automatic bit geom_ok(input int n_rows, input int out_w);
        return (out_w > 1) && (n_rows >= out_w) && ((n_rows % out_w) == 0);
    endfunction

    localparam bit DEF_GEOM_OK = geom_ok(DEF_N_ROWS, DEF_OUT_W);

endpackage

// File: rtl/parity_reduce.sv
// Combinational AND-XOR reduction of one Toeplitz row against the input block.
// Zero latency, no backpressure; a pipelined tree can drop in behind the same ports.
module parity_reduce #(
    parameter int ROW_W = 3072
) (
    input  logic [ROW_W-1:0] i_a,
    input  logic [ROW_W-1:0] i_b,
    output logic             o_y
);

    assign o_y = ^(i_a & i_b);

endmodule

// File: rtl/toeplitz_sched.sv
// Gates the row generator and packs one hash bit per row into OUT_W-bit words; word valid 1 cycle after its last bit.
// Backpressure: while a word waits for o_out_ready the generator is stalled via o_row_req=0.
module toeplitz_sched
    import toeplitz_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int N_ROWS = DEF_N_ROWS,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic             i_clk_in,
    input  logic             i_rst_n,
    input  logic             i_abort,
    input  logic             i_blk_valid,
    output logic             o_blk_ready,
    input  logic [ROW_W-1:0] i_blk_data,
    output logic             o_row_req,
    input  logic             i_row_valid,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out_data,
    output logic             o_blk_done,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(N_ROWS + 1);
    localparam int IDX_W = $clog2(OUT_W);

    if (!geom_ok(N_ROWS, OUT_W) || !DEF_GEOM_OK) begin : g_bad_geometry
        $error("toeplitz_sched: N_ROWS must be a non-zero multiple of OUT_W (OUT_W > 1)");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_live;
    logic [ROW_W-1:0]   r_blk_reg;
    logic [CNT_W-1:0]   r_row_cnt;
    logic [OUT_W-1:0]   r_shift;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;

    logic               w_bit;
    logic [IDX_W-1:0]   w_idx;
    logic               w_last;
    logic               w_cnt_full;
    logic               w_accept;
    logic [OUT_W-1:0]   w_word;

    parity_reduce #(.ROW_W(ROW_W)) u_parity (
        .i_a (i_row),
        .i_b (r_blk_reg),
        .o_y (w_bit)
    );

    assign w_idx      = IDX_W'(r_row_cnt % CNT_W'(OUT_W));
    assign w_last     = (w_idx == IDX_W'(OUT_W - 1));
    assign w_cnt_full = (r_row_cnt == CNT_W'(N_ROWS));
    assign w_accept   = i_blk_valid && o_blk_ready;

    always_comb begin
        w_word        = r_shift;
        w_word[w_idx] = w_bit;
    end

    // Held low until the first edge after reset release so no block is taken during reset.
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_row_req   = 1'b0;
        o_blk_done  = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                o_row_req = 1'b1;
                if (i_row_valid && w_last) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (i_out_ready) w_state_nxt = w_cnt_full ? S_DONE : S_RUN;
            end
            S_DONE: begin
                o_blk_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) w_state_nxt = S_IDLE;
    end

    assign o_blk_ready = r_live && (r_state == S_IDLE);

    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blk_reg   <= '0;
            r_row_cnt   <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_abort) begin
            r_row_cnt   <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_blk_reg <= i_blk_data;
                        r_row_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                S_RUN: begin
                    if (i_row_valid) begin
                        r_shift   <= w_word;
                        r_row_cnt <= r_row_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_out_data  <= w_word;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (i_out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_toeplitz_sched.sv
// Directed and randomized bench for toeplitz_sched: a small 8/4/2 instance and a default-geometry instance.
module tb_toeplitz_sched;

    localparam int SW = 8;
    localparam int SN = 4;
    localparam int SO = 2;
    localparam int DW = 3072;
    localparam int DN = 1024;
    localparam int DO = 32;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          abort_s, bv_s, brdy_s, rreq_s, rv_s, ov_s, ordy_s, bdone_s, busy_s;
    logic [SW-1:0] bd_s, row_s;
    logic [SO-1:0] od_s;

    logic          abort_d, bv_d, brdy_d, rreq_d, rv_d, ov_d, ordy_d, bdone_d, busy_d;
    logic [DW-1:0] bd_d, row_d;
    logic [DO-1:0] od_d;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    s_rows [4];

    always #5 clk = ~clk;

    toeplitz_sched #(.ROW_W(SW), .N_ROWS(SN), .OUT_W(SO)) dut_s (
        .i_clk_in   (clk),
        .i_rst_n    (rst_n),
        .i_abort    (abort_s),
        .i_blk_valid(bv_s),
        .o_blk_ready(brdy_s),
        .i_blk_data (bd_s),
        .o_row_req  (rreq_s),
        .i_row_valid(rv_s),
        .i_row      (row_s),
        .o_out_valid(ov_s),
        .i_out_ready(ordy_s),
        .o_out_data (od_s),
        .o_blk_done (bdone_s),
        .o_busy     (busy_s)
    );

    toeplitz_sched dut_d (
        .i_clk_in   (clk),
        .i_rst_n    (rst_n),
        .i_abort    (abort_d),
        .i_blk_valid(bv_d),
        .o_blk_ready(brdy_d),
        .i_blk_data (bd_d),
        .o_row_req  (rreq_d),
        .i_row_valid(rv_d),
        .i_row      (row_d),
        .o_out_valid(ov_d),
        .i_out_ready(ordy_d),
        .o_out_data (od_d),
        .o_blk_done (bdone_d),
        .o_busy     (busy_d)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hash bit = parity of the number of block bits selected by the row.
    function automatic logic hbit(input logic [7:0] blk, input logic [7:0] r);
        return 1'($countones(blk & r) % 2);
    endfunction

    function automatic logic [1:0] exp_word(input logic [7:0] blk, input int w);
        logic [1:0] v;
        v[0] = hbit(blk, s_rows[2*w]);
        v[1] = hbit(blk, s_rows[2*w+1]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_s(input logic [7:0] d);
        bv_s = 1'b1;
        bd_s = d;
        tick();
        bv_s = 1'b0;
    endtask

    // Feeds s_rows whenever row_req is up (every gap-th cycle), with out_ready held high.
    task automatic run_s(input logic [7:0] blk, input int gap, output int nw,
                         output logic [1:0] w0, output logic [1:0] w1,
                         output int nd, output int hs2done, output int gap_viol);
        int ri;
        int hs;
        ri = 0; hs = -1;
        nw = 0; nd = 0; w0 = '0; w1 = '0; hs2done = -1; gap_viol = 0;
        ordy_s = 1'b1;
        send_s(blk);
        for (int c = 0; c < 200; c++) begin
            if (bdone_s) begin
                nd++;
                if (hs2done < 0) hs2done = c - hs;
            end
            if (ov_s) begin
                if (nw == 0) w0 = od_s; else w1 = od_s;
                nw++;
                hs = c;
            end
            if (ri < 4 && !ov_s && busy_s && !bdone_s && !rreq_s) gap_viol++;
            rv_s = 1'b0;
            if (rreq_s && ri < 4 && (c % gap) == 0) begin
                rv_s  = 1'b1;
                row_s = s_rows[ri];
                ri++;
            end
            tick();
        end
        rv_s = 1'b0;
    endtask

    int          nw, nd, hs2d, gv;
    logic [1:0]  w0, w1;
    logic [7:0]  blk;
    logic [DW-1:0] rowd;
    logic [DO-1:0] ew;
    bit          expq [$];
    int          nrows, nwd, ndd, done_c;

    initial begin
        rst_n = 1'b0;
        abort_s = 0; bv_s = 0; bd_s = '0; rv_s = 0; row_s = '0; ordy_s = 1;
        abort_d = 0; bv_d = 0; bd_d = '0; rv_d = 0; row_d = '0; ordy_d = 1;
        #3;
        chk("rst_blk_ready", 64'(brdy_s), 64'd0);
        chk("rst_row_req",   64'(rreq_s), 64'd0);
        chk("rst_out_valid", 64'(ov_s),   64'd0);
        chk("rst_out_data",  64'(od_s),   64'd0);
        chk("rst_blk_done",  64'(bdone_s), 64'd0);
        chk("rst_busy",      64'(busy_s), 64'd0);
        chk("rst_d_out_data", 64'(od_d),  64'd0);
        #4 rst_n = 1'b1;
        tick();
        chk("post_rst_blk_ready", 64'(brdy_s), 64'd1);

        // Nominal
        s_rows[0] = 8'hFF; s_rows[1] = 8'h01; s_rows[2] = 8'h80; s_rows[3] = 8'h0F;
        run_s(8'hA5, 1, nw, w0, w1, nd, hs2d, gv);
        chk("nom_words", 64'(nw), 64'd2);
        chk("nom_w0", 64'(w0), 64'(exp_word(8'hA5, 0)));
        chk("nom_w1", 64'(w1), 64'(exp_word(8'hA5, 1)));
        chk("nom_w0_const", 64'(w0), 64'h2);
        chk("nom_done_cnt", 64'(nd), 64'd1);
        chk("nom_hs_to_done", 64'(hs2d), 64'd1);

        // Backpressure on word 0 with ignored row strobes during the stall
        ordy_s = 1'b0;
        send_s(8'hA5);
        chk("bp_accept_rreq", 64'(rreq_s), 64'd1);
        rv_s = 1'b1; row_s = 8'hFF; tick();
        row_s = 8'h01; tick();
        chk("bp_ov", 64'(ov_s), 64'd1);
        chk("bp_od", 64'(od_s), 64'(exp_word(8'hA5, 0)));
        chk("bp_rreq", 64'(rreq_s), 64'd0);
        for (int i = 0; i < 5; i++) begin
            rv_s = 1'b1; row_s = 8'h80;
            tick();
            chk("bp_hold_ov", 64'(ov_s), 64'd1);
            chk("bp_hold_od", 64'(od_s), 64'h2);
            chk("bp_hold_rreq", 64'(rreq_s), 64'd0);
        end
        rv_s = 1'b0; ordy_s = 1'b1;
        tick();
        chk("bp_after_hs_ov", 64'(ov_s), 64'd0);
        chk("bp_after_hs_rreq", 64'(rreq_s), 64'd1);
        rv_s = 1'b1; row_s = 8'h80; tick();
        row_s = 8'h0F; tick();
        rv_s = 1'b0;
        chk("bp_w1", 64'(od_s), 64'(exp_word(8'hA5, 1)));
        chk("bp_w1_ov", 64'(ov_s), 64'd1);
        tick();
        chk("bp_done", 64'(bdone_s), 64'd1);
        tick();
        chk("bp_done_end", 64'(bdone_s), 64'd0);
        chk("bp_blk_ready", 64'(brdy_s), 64'd1);

        // Gapped rows
        run_s(8'hA5, 3, nw, w0, w1, nd, hs2d, gv);
        chk("gap_words", 64'(nw), 64'd2);
        chk("gap_w0", 64'(w0), 64'(exp_word(8'hA5, 0)));
        chk("gap_w1", 64'(w1), 64'(exp_word(8'hA5, 1)));
        chk("gap_rreq_drop", 64'(gv), 64'd0);
        chk("gap_done_cnt", 64'(nd), 64'd1);

        // Abort in RUN after one row
        send_s(8'hA5);
        rv_s = 1'b1; row_s = 8'hFF; tick();
        rv_s = 1'b0; abort_s = 1'b1; tick();
        abort_s = 1'b0;
        chk("abort_busy", 64'(busy_s), 64'd0);
        chk("abort_ov", 64'(ov_s), 64'd0);
        chk("abort_rreq", 64'(rreq_s), 64'd0);
        chk("abort_brdy", 64'(brdy_s), 64'd1);
        chk("abort_no_done", 64'(bdone_s), 64'd0);
        run_s(8'hA5, 1, nw, w0, w1, nd, hs2d, gv);
        chk("abort_next_w0", 64'(w0), 64'(exp_word(8'hA5, 0)));
        chk("abort_next_w1", 64'(w1), 64'(exp_word(8'hA5, 1)));
        chk("abort_next_done", 64'(nd), 64'd1);

        // Abort coincident with a block handshake drops the block
        bv_s = 1'b1; bd_s = 8'h3C; abort_s = 1'b1; tick();
        bv_s = 1'b0; abort_s = 1'b0;
        chk("abort_hs_busy", 64'(busy_s), 64'd0);
        chk("abort_hs_brdy", 64'(brdy_s), 64'd1);

        // Randomized small blocks with varying row gaps
        for (int k = 0; k < 4; k++) begin
            blk = 8'($urandom);
            for (int i = 0; i < 4; i++) s_rows[i] = 8'($urandom);
            run_s(blk, 1 + k % 3, nw, w0, w1, nd, hs2d, gv);
            chk("rnd_words", 64'(nw), 64'd2);
            chk("rnd_w0", 64'(w0), 64'(exp_word(blk, 0)));
            chk("rnd_w1", 64'(w1), 64'(exp_word(blk, 1)));
            chk("rnd_done", 64'(nd), 64'd1);
        end

        // Reset while a word waits in OUT
        ordy_s = 1'b0;
        send_s(8'hA5);
        rv_s = 1'b1; row_s = 8'hFF; tick();
        row_s = 8'h01; tick();
        rv_s = 1'b0;
        chk("rstout_ov_before", 64'(ov_s), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstout_ov", 64'(ov_s), 64'd0);
        chk("rstout_od", 64'(od_s), 64'd0);
        chk("rstout_rreq", 64'(rreq_s), 64'd0);
        chk("rstout_busy", 64'(busy_s), 64'd0);
        chk("rstout_brdy", 64'(brdy_s), 64'd0);
        chk("rstout_done", 64'(bdone_s), 64'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("rstout_brdy_release", 64'(brdy_s), 64'd0);
        tick();
        chk("rstout_brdy_next", 64'(brdy_s), 64'd1);
        ordy_s = 1'b1;

        // Default geometry: all-ones block, 1024 random rows, random gaps and backpressure
        nrows = 0; nwd = 0; ndd = 0; done_c = -1;
        bv_d = 1'b1; bd_d = '1; tick(); bv_d = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (bdone_d) begin
                ndd++;
                if (done_c < 0) done_c = c;
            end
            ordy_d = ($urandom_range(0, 3) != 0);
            if (ov_d && ordy_d) begin
                if (expq.size() >= DO) begin
                    for (int j = 0; j < DO; j++) ew[j] = expq.pop_front();
                end else begin
                    ew = 'x;
                end
                chk("dflt_word", 64'(od_d), 64'(ew));
                nwd++;
            end
            rv_d = 1'b0;
            if (rreq_d && nrows < DN && $urandom_range(0, 4) != 0) begin
                for (int i = 0; i < DW / 32; i++) rowd[i*32 +: 32] = $urandom;
                row_d = rowd;
                rv_d  = 1'b1;
                expq.push_back(bit'($countones(rowd) % 2));
                nrows++;
            end
            tick();
            if (done_c >= 0 && c > done_c + 5) break;
        end
        rv_d = 1'b0;
        chk("dflt_rows", 64'(nrows), 64'(DN));
        chk("dflt_words", 64'(nwd), 64'(DN / DO));
        chk("dflt_done_cnt", 64'(ndd), 64'd1);
        chk("dflt_idle", 64'(busy_d), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toeplitz_sched.md
# toeplitz_sched

Sequencer for the Toeplitz hash datapath. It accepts one ROW_W-bit input block and gates the row generator so it advances only when a hash bit can be absorbed. Each row is reduced against the block (XOR of row AND block) to one output bit, and the bits are packed into OUT_W-bit words with valid/ready backpressure. It sits between the input-block source, the row generator (whose sum_en strobe drives row_valid) and the downstream hash-word consumer.

## Interface
Parameters:
- ROW_W, 3072, width of a generator row and of the input block.
- N_ROWS, 1024, output bits per block; must be a multiple of OUT_W.
- OUT_W, 32, output word width.

Ports:
- clk_in  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous; forces return to IDLE from any state.
- blk_valid  in  1  input block offered.
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- blk_data  in  ROW_W  input block.
- row_req  out  1  generator may advance; high only in RUN.
- row_valid  in  1  generator row strobe (sum_en); ignored unless row_req.
- row  in  ROW_W  current Toeplitz row.
- out_valid  out  1  hash word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_W  packed hash bits, first bit in LSB.
- blk_done  out  1  one-cycle pulse after the last word of a block is accepted.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, OUT, DONE.
- IDLE: blk_ready=1. On blk_valid, capture blk_data into blk_reg, clear row_cnt and the word shifter, and go to RUN.
- RUN: row_req=1 (combinational from state). On each row_valid:
  - compute bit = ^(row & blk_reg);
  - write it to shifter[row_cnt % OUT_W];
  - increment row_cnt.
- RUN exit: when the written bit fills the word (row_cnt % OUT_W == OUT_W-1), load out_data with the completed word, set out_valid=1, and go to OUT on the same edge.
- OUT: row_req=0 (generator stalled). out_valid and out_data are held stable until out_ready. On the handshake, clear out_valid; go to DONE if row_cnt == N_ROWS, else back to RUN.
- DONE: blk_done=1 for one cycle, then IDLE.
- row_valid outside RUN: ignored, no count change.
- abort: highest priority. Next state is IDLE; out_valid, row_cnt and the shifter are cleared and no blk_done is issued. abort coincident with a blk handshake in IDLE: the block is dropped.
- Counter widths: row_cnt is $clog2(N_ROWS+1) bits; the word index is $clog2(OUT_W) bits. No wrap occurs because the block ends at N_ROWS.
- Reset values: blk_ready=0 while rst is low and 1 after release (IDLE); row_req=0; out_valid=0; out_data=0; blk_done=0; busy=0; blk_reg=0; state=IDLE.

## Timing
- Block accept to first row_req: 1 cycle.
- Row strobe to bit in shifter: same edge.
- Last bit of a word to out_valid: 1 cycle (registered).
- Throughput: 1 bit per cycle while row_valid is continuous. Each word costs at least 1 extra OUT cycle, so the minimum is OUT_W+1 cycles per word.
- out_ready held high: OUT lasts exactly 1 cycle.
- Last word handshake to blk_done: 1 cycle. blk_done to blk_ready: 1 cycle.
- Block period minimum: 1 + (N_ROWS/OUT_W)·(OUT_W+1) + 1 cycles.
- Reset mid-block: all state is discarded immediately (asynchronous); the generator sees row_req=0.

## Structure
- Shared package toeplitz_pkg holds:
  - the state enum (IDLE, RUN, OUT, DONE);
  - default ROW_W, N_ROWS and OUT_W constants;
  - a compile-time check that N_ROWS % OUT_W == 0.
- Sub-module parity_reduce (ROW_W): combinational ^(a & b). It is kept separate so a pipelined tree can replace it later.

## Test plan
Use ROW_W=8, N_ROWS=4, OUT_W=2 unless stated.
- Nominal: block 8'hA5; rows FF, 01, 80, 0F with out_ready=1 → bits 0,1,1,0; out_data 2'b10 then 2'b01; blk_done 1 cycle after the second handshake.
- Backpressure: same stimulus with out_ready=0 for 5 cycles on word 0 → out_data held at 2'b10; row_req=0 throughout; row_valid pulses during the stall are ignored and row_cnt stays 2.
- Gapped rows: row_valid every 3rd cycle → identical words; row_req stays high in RUN.
- Abort in RUN after 1 row → IDLE next cycle; out_valid=0; no blk_done; the next block A5 yields the nominal result.
- Reset mid-OUT → all outputs 0 immediately; blk_ready=1 one cycle after release.
- Default parameters, block all-ones, 1024 random rows → each word matches a reference model of popcount(row) parity; 32 words; blk_done once.
